// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game-flow controller: state encoding and
// classification helpers used by the FSM and its timers.
package game_flow_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    // Codes are consumed directly by the renderer / game logic.
    typedef enum logic [STATE_W-1:0] {
        STATE_START   = 3'd0,
        STATE_INGAME  = 3'd1,
        STATE_WON     = 3'd2,
        STATE_OVER    = 3'd3,
        STATE_PAUSE   = 3'd4,
        STATE_LEVELUP = 3'd5,
        STATE_RESPAWN = 3'd6
    } state_e;

    // States whose entry re-arms the key hold-off window.
    function automatic logic is_holdoff_state(input state_e s);
        return (s == STATE_START) || (s == STATE_WON) ||
               (s == STATE_OVER)  || (s == STATE_PAUSE);
    endfunction

    // States that show a timed banner before returning to play.
    function automatic logic is_banner_state(input state_e s);
        return (s == STATE_LEVELUP) || (s == STATE_RESPAWN);
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Rising-edge detector with a registered pulse output.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous reset, active low (clears history and pulse)
//   i_level  level-sensitive inputs
//   o_rise   one-cycle pulse per bit, one cycle after the input rises
module key_edge_det #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_hist;
    logic [WIDTH-1:0] r_rise;

    // History and pulse registered together; a held input yields one pulse only.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_rise <= '0;
        end else begin
            r_hist <= i_level;
            r_rise <= i_level & ~r_hist;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow controller: start / play / pause / level-up /
// respawn / won / over sequencing with a lives counter, level progression,
// edge-detected key events and a post-transition key hold-off.
// Ports:
//   iClk, iRst_n   clock and synchronous active-low reset
//   iKeys          direction/action keys (any bit counts as a press)
//   iKey_pause     pause key
//   iGame_won      level cleared (honoured in INGAME only)
//   iGame_over     life lost (honoured in INGAME only)
//   oState         current state code
//   oLevel         current level, 0-based
//   oLives         remaining lives
//   oNew_game      one-cycle pulse on START -> INGAME
//   oState_chg     one-cycle pulse in the first cycle of each new state
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned NUM_LEVELS  = 4,
    parameter int unsigned NUM_LIVES   = 3,
    parameter int unsigned HOLDOFF_CYC = 1024,
    parameter int unsigned BANNER_CYC  = 512,
    localparam int unsigned LEVEL_W    = ($clog2(NUM_LEVELS) > 0) ? $clog2(NUM_LEVELS) : 1,
    localparam int unsigned LIVES_W    = ($clog2(NUM_LIVES + 1) > 0) ? $clog2(NUM_LIVES + 1) : 1
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic [NUM_KEYS-1:0] iKeys,
    input  logic                iKey_pause,
    input  logic                iGame_won,
    input  logic                iGame_over,
    output logic [STATE_W-1:0]  oState,
    output logic [LEVEL_W-1:0]  oLevel,
    output logic [LIVES_W-1:0]  oLives,
    output logic                oNew_game,
    output logic                oState_chg
);

    localparam int unsigned HOLD_W   = ($clog2(HOLDOFF_CYC + 1) > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam int unsigned BANNER_W = ($clog2(BANNER_CYC + 1) > 0) ? $clog2(BANNER_CYC + 1) : 1;

    state_e              r_state;
    logic [LEVEL_W-1:0]  r_level;
    logic [LIVES_W-1:0]  r_lives;
    logic                r_new_game;
    logic                r_state_chg;
    logic [HOLD_W-1:0]   r_holdoff;
    logic [BANNER_W-1:0] r_banner;

    state_e              w_state_nxt;
    logic [LEVEL_W-1:0]  w_level_nxt;
    logic [LIVES_W-1:0]  w_lives_nxt;
    logic                w_new_game_nxt;
    logic                w_enter;
    logic                w_any_key;
    logic                w_key_ev;
    logic                w_pause_ev;
    logic                w_key_ok;
    logic                w_pause_ok;

    // Any key counts as a press, so the OR is edge-detected as one event.
    assign w_any_key = |iKeys;

    key_edge_det #(.WIDTH(1)) u_key_edge (
        .i_clk   (iClk),
        .i_rst_n (iRst_n),
        .i_level (w_any_key),
        .o_rise  (w_key_ev)
    );

    key_edge_det #(.WIDTH(1)) u_pause_edge (
        .i_clk   (iClk),
        .i_rst_n (iRst_n),
        .i_level (iKey_pause),
        .o_rise  (w_pause_ev)
    );

    // Events during hold-off are dropped, not queued.
    assign w_key_ok   = w_key_ev   && (r_holdoff == '0);
    assign w_pause_ok = w_pause_ev && (r_holdoff == '0);
    assign w_enter    = (w_state_nxt != r_state);

    // State, level, lives and pulse registers.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state     <= STATE_START;
            r_level     <= '0;
            r_lives     <= LIVES_W'(NUM_LIVES);
            r_new_game  <= 1'b0;
            r_state_chg <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_lives     <= w_lives_nxt;
            r_new_game  <= w_new_game_nxt;
            r_state_chg <= w_enter;
        end
    end

    // Hold-off and banner timers; both reload on entry and count down to 0.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_holdoff <= HOLD_W'(HOLDOFF_CYC);
            r_banner  <= '0;
        end else begin
            if (w_enter && is_holdoff_state(w_state_nxt)) begin
                r_holdoff <= HOLD_W'(HOLDOFF_CYC);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - HOLD_W'(1);
            end

            if (w_enter && is_banner_state(w_state_nxt)) begin
                r_banner <= BANNER_W'(BANNER_CYC);
            end else if (r_banner != '0) begin
                r_banner <= r_banner - BANNER_W'(1);
            end
        end
    end

    // Next-state, level and lives logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_level_nxt    = r_level;
        w_lives_nxt    = r_lives;
        w_new_game_nxt = 1'b0;

        case (r_state)
            STATE_START: begin
                if (w_key_ok) begin
                    w_state_nxt    = STATE_INGAME;
                    w_level_nxt    = '0;
                    w_lives_nxt    = LIVES_W'(NUM_LIVES);
                    w_new_game_nxt = 1'b1;
                end
            end

            // Life loss outranks level clear, which outranks pause.
            STATE_INGAME: begin
                if (iGame_over) begin
                    if (r_lives <= LIVES_W'(1)) begin
                        w_state_nxt = STATE_OVER;
                        w_lives_nxt = '0;
                    end else begin
                        w_state_nxt = STATE_RESPAWN;
                        w_lives_nxt = r_lives - LIVES_W'(1);
                    end
                end else if (iGame_won) begin
                    if (r_level >= LEVEL_W'(NUM_LEVELS - 1)) begin
                        w_state_nxt = STATE_WON;
                    end else begin
                        w_state_nxt = STATE_LEVELUP;
                        w_level_nxt = r_level + LEVEL_W'(1);
                    end
                end else if (w_pause_ev) begin
                    w_state_nxt = STATE_PAUSE;
                end
            end

            STATE_PAUSE: begin
                if (w_pause_ok) begin
                    w_state_nxt = STATE_INGAME;
                end
            end

            STATE_LEVELUP, STATE_RESPAWN: begin
                if (r_banner == '0) begin
                    w_state_nxt = STATE_INGAME;
                end
            end

            STATE_WON, STATE_OVER: begin
                if (w_key_ok || w_pause_ok) begin
                    w_state_nxt = STATE_START;
                end
            end

            // Unused code 7 recovers to START.
            default: begin
                w_state_nxt = STATE_START;
            end
        endcase
    end

    assign oState     = r_state;
    assign oLevel     = r_level;
    assign oLives     = r_lives;
    assign oNew_game  = r_new_game;
    assign oState_chg = r_state_chg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus pushes hand-computed
// expectations (state, level, lives, pulses, cycle) into a queue; a monitor
// pops one entry on every oState_chg pulse or explicit probe request.
module tb_game_flow_ctrl;
    import game_flow_ctrl_pkg::*;

    localparam int unsigned NK = 4;
    localparam int unsigned NL = 4;
    localparam int unsigned NV = 3;
    localparam int unsigned H  = 20;
    localparam int unsigned B  = 10;

    logic          clk;
    logic          iRst_n;
    logic [NK-1:0] iKeys;
    logic          iKey_pause;
    logic          iGame_won;
    logic          iGame_over;
    logic [2:0]    oState;
    logic [1:0]    oLevel;
    logic [1:0]    oLives;
    logic          oNew_game;
    logic          oState_chg;

    typedef struct {
        string tag;
        int    st;
        int    lvl;
        int    lives;
        bit    ng;
        bit    chg;
        int    at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t end_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   probe_req = 1'b0;

    game_flow_ctrl #(
        .NUM_KEYS    (NK),
        .NUM_LEVELS  (NL),
        .NUM_LIVES   (NV),
        .HOLDOFF_CYC (H),
        .BANNER_CYC  (B)
    ) dut (
        .iClk       (clk),
        .iRst_n     (iRst_n),
        .iKeys      (iKeys),
        .iKey_pause (iKey_pause),
        .iGame_won  (iGame_won),
        .iGame_over (iGame_over),
        .oState     (oState),
        .oLevel     (oLevel),
        .oLives     (oLives),
        .oNew_game  (oNew_game),
        .oState_chg (oState_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare on every state-change pulse or probe request.
    always @(negedge clk) begin
        if (probe_req || oState_chg) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected: state=%0d level=%0d lives=%0d chg=%0b at cycle %0d, no event was required",
                         oState, oLevel, oLives, oState_chg, cyc);
            end else begin
                mon_e = q.pop_front();
                if (int'(oState) != mon_e.st || int'(oLevel) != mon_e.lvl ||
                    int'(oLives) != mon_e.lives || oNew_game != mon_e.ng ||
                    oState_chg != mon_e.chg || cyc != mon_e.at) begin
                    n_err++;
                    $display("FAIL %s: got state=%0d level=%0d lives=%0d new_game=%0b chg=%0b cycle=%0d; required state=%0d level=%0d lives=%0d new_game=%0b chg=%0b cycle=%0d",
                             mon_e.tag, oState, oLevel, oLives, oNew_game, oState_chg, cyc,
                             mon_e.st, mon_e.lvl, mon_e.lives, mon_e.ng, mon_e.chg, mon_e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d expectations pending", q.size());
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input state_e st, input int lvl, input int lives,
                        input bit ng, input bit chg, input int at);
        exp_t e;
        e.tag = tag; e.st = int'(st); e.lvl = lvl; e.lives = lives;
        e.ng = ng; e.chg = chg; e.at = at;
        q.push_back(e);
    endtask

    task automatic probe(input string tag, input state_e st, input int lvl, input int lives);
        push(tag, st, lvl, lives, 1'b0, 1'b0, cyc);
        probe_req = 1'b1;
        tick(1);
        probe_req = 1'b0;
    endtask

    task automatic pulse_keys(input logic [NK-1:0] k);
        iKeys = k;
        tick(1);
        iKeys = '0;
        tick(1);
    endtask

    task automatic pulse_pause();
        iKey_pause = 1'b1;
        tick(1);
        iKey_pause = 1'b0;
        tick(1);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick(1);
    endtask

    // START -> INGAME after hold-off; key held several cycles must not retrigger.
    task automatic start_game(input string tag);
        int d;
        tick(H + 2);
        d = cyc;
        push(tag, STATE_INGAME, 0, NV, 1'b1, 1'b1, d + 2);
        iKeys = 4'b0001;
        tick(6);
        iKeys = '0;
        tick(2);
    endtask

    // One-cycle game input in INGAME; follow=1 also expects the banner exit.
    task automatic step_in_game(input string tag, input bit over, input bit won, input bit pse,
                                input state_e exp_st, input int exp_lvl, input int exp_lives,
                                input bit follow);
        int d;
        d = cyc;
        iGame_over = over;
        iGame_won  = won;
        iKey_pause = pse;
        push(tag, exp_st, exp_lvl, exp_lives, 1'b0, 1'b1, d + 1);
        if (follow) push({tag, "_exit"}, STATE_INGAME, exp_lvl, exp_lives, 1'b0, 1'b1, d + 1 + B + 1);
        tick(1);
        iGame_over = 1'b0;
        iGame_won  = 1'b0;
        iKey_pause = 1'b0;
        if (follow) begin
            tick(B / 2);
            iGame_over = 1'b1;
            tick(1);
            iGame_over = 1'b0;
            tick(B / 2 + 2);
        end else begin
            tick(2);
        end
    endtask

    initial begin
        int d;
        int e;
        iRst_n     = 1'b0;
        iKeys      = '0;
        iKey_pause = 1'b0;
        iGame_won  = 1'b0;
        iGame_over = 1'b0;

        tick(2);
        probe("reset", STATE_START, 0, NV);
        iRst_n = 1'b1;

        tick(2);
        pulse_keys(4'b0001);
        tick(1);
        probe("start_holdoff", STATE_START, 0, NV);
        start_game("start1");

        step_in_game("over1", 1'b1, 1'b0, 1'b0, STATE_RESPAWN, 0, 2, 1'b1);
        step_in_game("over2", 1'b1, 1'b0, 1'b0, STATE_RESPAWN, 0, 1, 1'b1);
        step_in_game("over3", 1'b1, 1'b0, 1'b0, STATE_OVER,    0, 0, 1'b0);

        pulse_keys(4'b0010);
        tick(H + 2);
        d = cyc;
        push("over_exit", STATE_START, 0, 0, 1'b0, 1'b1, d + 2);
        pulse_keys(4'b0100);
        tick(2);

        start_game("start2");
        step_in_game("won1", 1'b0, 1'b1, 1'b0, STATE_LEVELUP, 1, NV, 1'b1);
        step_in_game("won2", 1'b0, 1'b1, 1'b0, STATE_LEVELUP, 2, NV, 1'b1);
        step_in_game("won3", 1'b0, 1'b1, 1'b0, STATE_LEVELUP, 3, NV, 1'b1);
        step_in_game("won4", 1'b0, 1'b1, 1'b0, STATE_WON,     3, NV, 1'b0);

        tick(H + 2);
        d = cyc;
        push("won_exit", STATE_START, 3, NV, 1'b0, 1'b1, d + 2);
        pulse_pause();
        tick(2);

        start_game("start3");
        step_in_game("won_a", 1'b0, 1'b1, 1'b0, STATE_LEVELUP, 1, NV, 1'b1);
        step_in_game("priority", 1'b1, 1'b1, 1'b1, STATE_RESPAWN, 1, 2, 1'b1);

        d = cyc;
        push("pause_in", STATE_PAUSE, 1, 2, 1'b0, 1'b1, d + 2);
        pulse_pause();
        e = d + 2;
        pulse_keys(4'b1000);
        iGame_over = 1'b1;
        tick(1);
        iGame_over = 1'b0;
        wait_until(e + H - 3);
        pulse_pause();
        wait_until(e + H - 1);
        push("pause_out", STATE_INGAME, 1, 2, 1'b0, 1'b1, cyc + 2);
        pulse_pause();
        tick(2);

        #2 iRst_n = 1'b0;
        #1 iRst_n = 1'b1;
        probe("rst_glitch", STATE_INGAME, 1, 2);

        step_in_game("won_b", 1'b0, 1'b1, 1'b0, STATE_LEVELUP, 2, 2, 1'b0);
        iRst_n = 1'b0;
        tick(1);
        probe("mid_reset", STATE_START, 0, NV);
        iRst_n = 1'b1;
        start_game("start4");

        tick(5);
        while (q.size() > 0) begin
            end_e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: event never observed, required state=%0d at cycle %0d",
                     end_e.tag, end_e.st, end_e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
